// File: rtl/bsg_vanilla_dma_pkg.sv
// Shared types and constants for the vanilla DMA remote transmitter:
// the FSM state encoding, the remote store packet layout and the
// completion value written back to local memory.
package bsg_vanilla_dma_pkg;

   localparam int dma_data_width_gp    = 32;
   localparam int dma_x_cord_width_gp  = 6;
   localparam int dma_y_cord_width_gp  = 6;
   localparam int dma_addr_width_gp    = 12;
   localparam int dma_mask_width_gp    = dma_data_width_gp >> 3;

   // Each remote store moves one 32-bit word.
   localparam int dma_word_bytes_gp    = 4;

   // Value written to the local completion flag.
   localparam int dma_wb_done_value_gp = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      DRAIN = 2'd2,
      WB    = 2'd3
   } dma_tx_state_e;

   typedef struct packed {
      logic [dma_x_cord_width_gp-1:0] x;
      logic [dma_y_cord_width_gp-1:0] y;
      logic [dma_addr_width_gp-1:0]   addr;
      logic [dma_mask_width_gp-1:0]   mask;
      logic [dma_data_width_gp-1:0]   data;
   } dma_remote_pkt_s;

endpackage

// File: rtl/vanilla_dma_credit_counter.sv
// Outstanding remote store tracker. Increments on each issued store,
// decrements on each returned credit; both in one cycle cancel out.
// A return with nothing outstanding is dropped and flagged by an assertion.
module vanilla_dma_credit_counter #(
   parameter int max_p   = 16,
   parameter int width_p = $clog2(max_p + 1)
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic inc_i,
   input  logic dec_i,
   output logic full_o,
   output logic empty_o
);

   logic [width_p-1:0] count_q;
   logic               dec_eff;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q >= width_p'(max_p));
   assign dec_eff = dec_i & ~empty_o;

   // Up/down count with simultaneous increment and decrement holding the value.
   always_ff @(posedge clk_i) begin
      // NOTE: state is updated with <= so every flop samples pre-edge values.
      if (!reset_n_i) begin
         count_q <= '0;
      end else begin
         unique case ({inc_i, dec_eff})
            2'b10:   count_q <= count_q + width_p'(1);
            2'b01:   count_q <= count_q - width_p'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   underflow_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(dec_i && empty_o));

endmodule

// File: rtl/vanilla_dma_remote_tx.sv
// Push-side network transmitter of the vanilla DMA engine. Turns words read
// from local DMEM into remote stores to (x, y, addr), limits outstanding
// stores by credits, and writes a completion flag locally once all stores
// are acknowledged.
// Optional stall statistics counter: define VANILLA_DMA_TX_STATS_EN.
module vanilla_dma_remote_tx
   import bsg_vanilla_dma_pkg::*;
#(
   parameter int data_width_p      = dma_data_width_gp,
   parameter int max_out_credits_p = 16,
   parameter int x_cord_width_p    = dma_x_cord_width_gp,
   parameter int y_cord_width_p    = dma_y_cord_width_gp,
   parameter int addr_width_p      = dma_addr_width_gp
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        start_i,
   input  logic [addr_width_p-1:0]     remote_addr_i,
   input  logic [x_cord_width_p-1:0]   remote_x_i,
   input  logic [y_cord_width_p-1:0]   remote_y_i,
   input  logic [addr_width_p-1:0]     num_bytes_i,
   input  logic [addr_width_p-1:0]     wb_addr_i,
   input  logic                        in_v_i,
   input  logic [data_width_p-1:0]     in_data_i,
   output logic                        in_ready_o,
   output logic                        pkt_v_o,
   output logic [x_cord_width_p-1:0]   pkt_x_o,
   output logic [y_cord_width_p-1:0]   pkt_y_o,
   output logic [addr_width_p-1:0]     pkt_addr_o,
   output logic [data_width_p-1:0]     pkt_data_o,
   output logic [(data_width_p>>3)-1:0] pkt_mask_o,
   input  logic                        pkt_ready_i,
   input  logic                        credit_return_i,
   output logic                        wb_v_o,
   output logic [addr_width_p-1:0]     wb_addr_o,
   output logic [data_width_p-1:0]     wb_data_o,
   input  logic                        wb_yumi_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic [31:0]                 stall_cycles_o
);

   dma_tx_state_e               state_q;
   logic [addr_width_p-1:0]     addr_q;
   logic [addr_width_p-1:0]     wb_addr_q;
   logic [addr_width_p-1:0]     remaining_q;
   logic [x_cord_width_p-1:0]   x_q;
   logic [y_cord_width_p-1:0]   y_q;
   logic [addr_width_p-1:0]     start_words;

   logic            in_send;
   logic            credit_full;
   logic            credit_empty;
   logic            credit_ok;
   logic            fire;
   dma_remote_pkt_s pkt;

   assign start_words = num_bytes_i >> 2;
   assign in_send     = (state_q == SEND);
   assign credit_ok   = ~credit_full;

   // Handshakes are combinational so a word can move every cycle.
   assign pkt_v_o     = in_send & in_v_i & credit_ok;
   assign in_ready_o  = in_send & pkt_ready_i & credit_ok;
   assign fire        = in_send & in_v_i & pkt_ready_i & credit_ok;

   vanilla_dma_credit_counter #(
      .max_p (max_out_credits_p)
   ) credit_counter (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .inc_i     (fire),
      .dec_i     (credit_return_i),
      .full_o    (credit_full),
      .empty_o   (credit_empty)
   );

   // Assemble the outgoing store: header from latched job, data passed through.
   always_comb begin
      // NOTE: assign a default first so no path leaves a field unassigned (no latch).
      pkt      = '0;
      pkt.x    = x_q;
      pkt.y    = y_q;
      pkt.addr = addr_q;
      pkt.mask = '1;
      pkt.data = in_data_i;
   end

   assign pkt_x_o    = pkt.x;
   assign pkt_y_o    = pkt.y;
   assign pkt_addr_o = pkt.addr;
   assign pkt_mask_o = pkt.mask;
   assign pkt_data_o = pkt.data;

   assign wb_v_o     = (state_q == WB);
   assign wb_addr_o  = wb_addr_q;
   assign wb_data_o  = data_width_p'(dma_wb_done_value_gp);
   assign done_o     = (state_q == WB) & wb_yumi_i;
   assign busy_o     = (state_q != IDLE);

   // Transfer sequencer: latch the job, stream words, drain credits, write back.
   always_ff @(posedge clk_i) begin
      // NOTE: the job registers are reset alongside the state so outputs read 0 after reset.
      if (!reset_n_i) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wb_addr_q   <= '0;
         remaining_q <= '0;
         x_q         <= '0;
         y_q         <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  addr_q      <= remote_addr_i;
                  x_q         <= remote_x_i;
                  y_q         <= remote_y_i;
                  wb_addr_q   <= wb_addr_i;
                  remaining_q <= start_words;
                  state_q     <= (start_words == '0) ? WB : SEND;
               end
            end
            SEND: begin
               if (fire) begin
                  addr_q      <= addr_q + addr_width_p'(dma_word_bytes_gp);
                  remaining_q <= remaining_q - addr_width_p'(1);
                  if (remaining_q == addr_width_p'(1)) begin
                     state_q <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (credit_empty) begin
                  state_q <= WB;
               end
            end
            WB: begin
               if (wb_yumi_i) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef VANILLA_DMA_TX_STATS_EN
   logic [31:0] stall_q;

   // Count cycles where a word was offered in SEND but could not move.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         stall_q <= '0;
      end else if ((state_q == IDLE) && start_i) begin
         stall_q <= '0;
      end else if (in_send && in_v_i && !fire && (stall_q != '1)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cycles_o = stall_q;
`else
   assign stall_cycles_o = '0;
`endif

endmodule
